adc_acq_sequencer: RTL and testbench
====================================

// Module: adc_acq_sequencer
//
// PURPOSE
//   Sample-rate sequencer upstream of adc_spi_controller. Generates the ADC CNV
//   pulse at a programmable period, waits the ADC conversion time, triggers the
//   SPI readout, and pushes each 32-bit result into an AXI-Stream FIFO. It also
//   serialises host register-write requests into gaps between conversions.
//
// PARAMETERS
//   CNV_HIGH_CYCLES   4    adc_cnv high time in spi_clk cycles (>=1)
//   CONV_WAIT_CYCLES  30   cycles from adc_cnv falling to start_conversion (>=1)
//   DIV_WIDTH         16   width of rate_div
//   FIFO_DEPTH        16   sample FIFO entries, power of two (>=2)
//
// PORTS
//   spi_clk             in   1          single clock for the whole block
//   spi_resetn          in   1          asynchronous, active-low reset
//   enable              in   1          1 = periodic sampling running
//   rate_div            in   DIV_WIDTH  sample period = rate_div+1 cycles
//   clear_status        in   1          1-cycle pulse, clears sticky flags
//   reg_write_req       in   1          level; host requests an ADC register write
//   reg_write_req_data  in   24         register write word, held while req high
//   reg_write_ack       out  1          1-cycle pulse, write finished
//   adc_cnv             out  1          ADC convert-start pin
//   start_conversion    out  1          1-cycle pulse to SPI controller
//   start_reg_write     out  1          1-cycle pulse to SPI controller
//   reg_write_data      out  24         registered copy of reg_write_req_data
//   conversion_data     in   32         result from SPI controller
//   conversion_done     in   1          1-cycle pulse, conversion_data valid
//   reg_write_done      in   1          1-cycle pulse, write complete
//   spi_busy            in   1          SPI controller busy
//   m_axis_tdata        out  32         oldest FIFO sample
//   m_axis_tvalid       out  1          FIFO not empty
//   m_axis_tready       in   1          consumer ready
//   overrun             out  1          sticky: FIFO push dropped
//   missed_tick         out  1          sticky: period tick arrived while not IDLE
//
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, FIFO empty, period counter 0.
//   - Period counter: enable=0 -> counter held 0. enable=1 -> tick when counter==0,
//     then reload rate_div; else decrement. First tick on first cycle enable=1.
//   - FSM IDLE: tick -> adc_cnv<=1, CNV_HIGH (tick has priority over writes).
//     Else reg_write_req && !spi_busy -> latch reg_write_data, pulse
//     start_reg_write, WRITE.
//   - CNV_HIGH: hold CNV_HIGH_CYCLES cycles, then adc_cnv<=0, CNV_WAIT.
//   - CNV_WAIT: after CONV_WAIT_CYCLES, pulse start_conversion once, READ.
//   - READ: wait conversion_done; push conversion_data; -> IDLE same cycle.
//   - WRITE: wait reg_write_done; pulse reg_write_ack; -> IDLE. Host must drop
//     reg_write_req on ack; a req still high next IDLE cycle is a new write.
//   - Tick while FSM not IDLE: discarded, missed_tick<=1.
//   - enable falling mid-sequence: current conversion/write completes normally.
//   - FIFO: first-word-fall-through; pop on tvalid&&tready. Push accepted if not
//     full or pop in same cycle; otherwise sample dropped, overrun<=1.
//   - clear_status coincident with a new set event: set wins.
//   - Latency: tick -> adc_cnv high 1 cycle; conversion_done -> tvalid 1 cycle
//     (FIFO previously empty).
//
// CONFIGURATION
//   ADC_ACQ_DROP_COUNT_EN defined: adds output drop_count[15:0]; increments on each
//     dropped push and each missed tick (+2 if both same cycle), saturates at
//     16'hFFFF, cleared by clear_status. Undefined: port and logic absent; sticky
//     flags unchanged.
//
// TESTING
//   - enable=1, rate_div=99, tready=1, SPI model returns 0xA5A5_0001+n -> adc_cnv
//     rises every 100 cycles, high 4 cycles; samples arrive in order, no flags.
//   - rate_div=9 (shorter than sequence) -> missed_tick=1, each sequence completes,
//     clear_status clears flag next cycle.
//   - tready=0 for 20 samples, FIFO_DEPTH=16 -> 16 samples held, overrun=1;
//     release -> exactly 16 samples drained in order (oldest first).
//   - reg_write_req with 0x12_3456 while enable=0 -> one start_reg_write, data
//     0x123456, reg_write_ack 1 cycle after reg_write_done.
//   - tick and reg_write_req same IDLE cycle -> conversion first, write follows.
//   - spi_resetn low during READ -> all outputs 0, FIFO empty; with
//     ADC_ACQ_DROP_COUNT_EN, drop_count=0 and saturates at 0xFFFF in overflow run.

Source files
------------

// File: rtl/adc_acq_sequencer_if.sv
//==============================================================================
// Module      : adc_acq_sequencer_if
// Description : Signal bundle for adc_acq_sequencer. Carries the host control
//               inputs, the host register-write handshake, the ADC CNV pin,
//               the SPI controller handshake and the AXI-Stream sample output.
//               master modport : sequencer side (adc_acq_sequencer)
//               slave modport  : environment side (host, SPI controller, sink)
//               Optional macro : ADC_ACQ_DROP_COUNT_EN adds drop_count[15:0].
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface adc_acq_sequencer_if #(
    parameter int DIV_WIDTH = 16
);
    // host control
    logic                 enable;
    logic [DIV_WIDTH-1:0] rate_div;
    logic                 clear_status;
    logic                 reg_write_req;
    logic [23:0]          reg_write_req_data;
    logic                 reg_write_ack;
    // ADC pin and SPI controller handshake
    logic                 adc_cnv;
    logic                 start_conversion;
    logic                 start_reg_write;
    logic [23:0]          reg_write_data;
    logic [31:0]          conversion_data;
    logic                 conversion_done;
    logic                 reg_write_done;
    logic                 spi_busy;
    // sample stream
    logic [31:0]          m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    // status
    logic                 overrun;
    logic                 missed_tick;
`ifdef ADC_ACQ_DROP_COUNT_EN
    logic [15:0]          drop_count;
`endif

    modport master (
        input  enable, rate_div, clear_status, reg_write_req, reg_write_req_data,
        input  conversion_data, conversion_done, reg_write_done, spi_busy,
        input  m_axis_tready,
`ifdef ADC_ACQ_DROP_COUNT_EN
        output drop_count,
`endif
        output reg_write_ack, adc_cnv, start_conversion, start_reg_write,
        output reg_write_data, m_axis_tdata, m_axis_tvalid, overrun, missed_tick
    );

    modport slave (
        output enable, rate_div, clear_status, reg_write_req, reg_write_req_data,
        output conversion_data, conversion_done, reg_write_done, spi_busy,
        output m_axis_tready,
`ifdef ADC_ACQ_DROP_COUNT_EN
        input  drop_count,
`endif
        input  reg_write_ack, adc_cnv, start_conversion, start_reg_write,
        input  reg_write_data, m_axis_tdata, m_axis_tvalid, overrun, missed_tick
    );
endinterface

`default_nettype wire

// File: rtl/adc_acq_sequencer.sv
//==============================================================================
// Module      : adc_acq_sequencer
// Description : Sample-rate sequencer in front of the ADC SPI controller.
//               A period counter issues a tick every rate_div+1 cycles; each
//               tick drives the ADC CNV pin high, waits the conversion time,
//               triggers the SPI readout and pushes the 32-bit result into a
//               first-word-fall-through sample FIFO (AXI-Stream master).
//               Host register writes are slotted into idle gaps.
// Ports       : spi_clk    - single clock
//               spi_resetn - asynchronous active-low reset
//               bus        - adc_acq_sequencer_if.master (host control, SPI
//                            handshake, CNV pin, sample stream, status flags)
// Options     : ADC_ACQ_DROP_COUNT_EN - adds a saturating 16-bit counter of
//               dropped samples plus missed ticks (bus.drop_count).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module adc_acq_sequencer #(
    parameter int CNV_HIGH_CYCLES  = 4,
    parameter int CONV_WAIT_CYCLES = 30,
    parameter int DIV_WIDTH        = 16,
    parameter int FIFO_DEPTH       = 16
) (
    input  wire logic           spi_clk,
    input  wire logic           spi_resetn,
    adc_acq_sequencer_if.master bus
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int c_PH_MAX = (CNV_HIGH_CYCLES > CONV_WAIT_CYCLES) ?
                              CNV_HIGH_CYCLES : CONV_WAIT_CYCLES;
    localparam int c_PH_W   = $clog2(c_PH_MAX) + 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);

    localparam logic [c_PH_W-1:0] c_CNV_LAST  = c_PH_W'(CNV_HIGH_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_WAIT_LAST = c_PH_W'(CONV_WAIT_CYCLES - 1);
    localparam logic [c_AW:0]     c_FULL      = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_CNV_HIGH = 3'd1;
    localparam logic [2:0] c_ST_CNV_WAIT = 3'd2;
    localparam logic [2:0] c_ST_READ     = 3'd3;
    localparam logic [2:0] c_ST_WRITE    = 3'd4;

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_period_cnt;
    logic                 w_tick;

    logic [2:0]           r_state;
    logic [c_PH_W-1:0]    r_phase_cnt;
    logic                 r_adc_cnv;
    logic                 r_start_conv;
    logic                 r_start_wr;
    logic [23:0]          r_wr_data;
    logic                 r_wr_ack;

    logic [31:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic                 w_tvalid;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_missed;

    logic                 r_overrun;
    logic                 r_missed_tick;

    //--------------------------------------------------------------------------
    // Period counter: counter==0 with enable high is a tick, so the first tick
    // lands on the very first enabled cycle and then every rate_div+1 cycles.
    //--------------------------------------------------------------------------
    assign w_tick = bus.enable && (r_period_cnt == '0);

    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            r_period_cnt <= '0;
        end else if (!bus.enable) begin
            r_period_cnt <= '0;
        end else if (w_tick) begin
            r_period_cnt <= bus.rate_div;
        end else begin
            r_period_cnt <= r_period_cnt - 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer FSM. The counter runs in two phases: CNV high time, then the
    // conversion wait measured from the CNV falling edge. enable is not looked
    // at outside IDLE, so a sequence already started always runs to the end.
    //--------------------------------------------------------------------------
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            r_state      <= c_ST_IDLE;
            r_phase_cnt  <= '0;
            r_adc_cnv    <= 1'b0;
            r_start_conv <= 1'b0;
            r_start_wr   <= 1'b0;
            r_wr_data    <= '0;
            r_wr_ack     <= 1'b0;
        end else begin
            // single-cycle strobes
            r_start_conv <= 1'b0;
            r_start_wr   <= 1'b0;
            r_wr_ack     <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    // a sampling tick always beats a pending register write
                    if (w_tick) begin
                        r_adc_cnv   <= 1'b1;
                        r_phase_cnt <= '0;
                        r_state     <= c_ST_CNV_HIGH;
                    end else if (bus.reg_write_req && !bus.spi_busy) begin
                        r_wr_data   <= bus.reg_write_req_data;
                        r_start_wr  <= 1'b1;
                        r_state     <= c_ST_WRITE;
                    end
                end

                c_ST_CNV_HIGH: begin
                    if (r_phase_cnt == c_CNV_LAST) begin
                        r_adc_cnv   <= 1'b0;
                        r_phase_cnt <= '0;
                        r_state     <= c_ST_CNV_WAIT;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end

                c_ST_CNV_WAIT: begin
                    if (r_phase_cnt == c_WAIT_LAST) begin
                        r_start_conv <= 1'b1;
                        r_phase_cnt  <= '0;
                        r_state      <= c_ST_READ;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end

                c_ST_READ: begin
                    // the sample itself is pushed by the FIFO logic this cycle
                    if (bus.conversion_done) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_WRITE: begin
                    if (bus.reg_write_done) begin
                        r_wr_ack <= 1'b1;
                        r_state  <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_adc_cnv <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Sample FIFO (first-word-fall-through). A push into a full FIFO is still
    // accepted when the head is being popped in the same cycle.
    //--------------------------------------------------------------------------
    assign w_tvalid   = (r_count != '0);
    assign w_pop      = w_tvalid && bus.m_axis_tready;
    assign w_push_req = (r_state == c_ST_READ) && bus.conversion_done;
    assign w_push     = w_push_req && ((r_count != c_FULL) || w_pop);
    assign w_drop     = w_push_req && !w_push;
    assign w_missed   = w_tick && (r_state != c_ST_IDLE);

    // storage needs no reset: tdata is masked while the FIFO is empty
    always_ff @(posedge spi_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.conversion_data;
        end
    end

    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Sticky status flags; a set event in the same cycle as clear_status wins.
    //--------------------------------------------------------------------------
    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            r_overrun     <= 1'b0;
            r_missed_tick <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_status) begin
                r_overrun <= 1'b0;
            end
            if (w_missed) begin
                r_missed_tick <= 1'b1;
            end else if (bus.clear_status) begin
                r_missed_tick <= 1'b0;
            end
        end
    end

`ifdef ADC_ACQ_DROP_COUNT_EN
    //--------------------------------------------------------------------------
    // Loss counter: +1 per dropped sample, +1 per missed tick, saturating.
    // Events in the clear cycle are counted on top of the cleared value.
    //--------------------------------------------------------------------------
    logic [15:0] r_drop_count;
    logic [15:0] w_drop_base;
    logic [16:0] w_drop_sum;

    assign w_drop_base = bus.clear_status ? 16'h0000 : r_drop_count;
    assign w_drop_sum  = {1'b0, w_drop_base} + {16'h0000, w_drop} + {16'h0000, w_missed};

    always_ff @(posedge spi_clk or negedge spi_resetn) begin
        if (!spi_resetn) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign bus.drop_count = r_drop_count;
`endif

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.adc_cnv          = r_adc_cnv;
    assign bus.start_conversion = r_start_conv;
    assign bus.start_reg_write  = r_start_wr;
    assign bus.reg_write_data   = r_wr_data;
    assign bus.reg_write_ack    = r_wr_ack;
    assign bus.m_axis_tvalid    = w_tvalid;
    assign bus.m_axis_tdata     = w_tvalid ? r_mem[r_rd_ptr] : 32'h0000_0000;
    assign bus.overrun          = r_overrun;
    assign bus.missed_tick      = r_missed_tick;

endmodule

`default_nettype wire

// File: tb/tb_adc_acq_sequencer.sv
//==============================================================================
// Module      : tb_adc_acq_sequencer
// Description : Self-checking bench for adc_acq_sequencer. A behavioural SPI
//               controller / sink model produces conversion results with
//               random latency; accepted samples are queued as expectations
//               and a monitor compares every stream handshake against them.
//               Optional macro : ADC_ACQ_DROP_COUNT_EN (checks drop_count).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_adc_acq_sequencer;

    localparam int c_CNV_HIGH  = 4;
    localparam int c_CONV_WAIT = 30;
    localparam int c_DEPTH     = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    adc_acq_sequencer_if #(.DIV_WIDTH(16)) bus ();

    adc_acq_sequencer #(
        .CNV_HIGH_CYCLES  (c_CNV_HIGH),
        .CONV_WAIT_CYCLES (c_CONV_WAIT),
        .DIV_WIDTH        (16),
        .FIFO_DEPTH       (c_DEPTH)
    ) dut (
        .spi_clk    (clk),
        .spi_resetn (rstn),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference-model state
    logic [31:0] exp_q [$];
    int occ = 0, occ_now = 0;
    int smp_n = 0, drops = 0, drained = 0, wr_starts = 0;
    int conv_cnt = 0, wr_cnt = 0;
    int tready_mode = 1;
    int cyc = 0, last_rise = -1, rise_cyc = 0, fall_cyc = 0;
    int last_done_cyc = 0, wr_start_cyc = 0;
    logic prev_cnv = 1'b0, prev_wdone = 1'b0;
    logic [23:0] exp_wr_data = 24'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    //--------------------------------------------------------------------------
    // SPI controller + sink model: acts just after each rising edge
    //--------------------------------------------------------------------------
    always @(posedge clk) begin
        bit tr, pop;
        #1;
        if (!rstn) begin
            conv_cnt = 0; wr_cnt = 0; occ = 0; occ_now = 0;
            exp_q.delete();
            bus.conversion_done = 1'b0; bus.reg_write_done = 1'b0;
            bus.spi_busy = 1'b0; bus.conversion_data = 32'h0; bus.m_axis_tready = 1'b0;
        end else begin
            bus.conversion_done = 1'b0;
            bus.reg_write_done  = 1'b0;
            if (conv_cnt > 0) begin
                conv_cnt--;
                if (conv_cnt == 0) begin
                    bus.conversion_done = 1'b1;
                    bus.conversion_data = 32'hA5A5_0001 + smp_n;
                    smp_n++;
                end
            end
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) bus.reg_write_done = 1'b1;
            end
            if (bus.start_conversion) conv_cnt = $urandom_range(1, 12);
            if (bus.start_reg_write)  wr_cnt   = $urandom_range(1, 10);
            bus.spi_busy = (conv_cnt > 0) || (wr_cnt > 0);

            case (tready_mode)
                0:       tr = 1'b0;
                1:       tr = 1'b1;
                default: tr = 1'($urandom_range(0, 1));
            endcase
            bus.m_axis_tready = tr;

            // FIFO occupancy model: room exists if not full or head leaves now
            occ_now = occ;
            pop = (occ > 0) && tr;
            if (bus.conversion_done) begin
                if (occ < c_DEPTH || pop) begin
                    exp_q.push_back(bus.conversion_data);
                    occ++;
                end else begin
                    drops++;
                end
            end
            if (pop) occ--;
        end
    end

    //--------------------------------------------------------------------------
    // Monitor: samples DUT outputs on the falling edge
    //--------------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            chk("tvalid_vs_model", bus.m_axis_tvalid, occ_now > 0);
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sample_unexpected: got 0x%0h expected none", bus.m_axis_tdata);
                end else begin
                    chk("sample", bus.m_axis_tdata, exp_q.pop_front());
                end
                drained++;
            end
            if (!bus.enable) last_rise = -1;
            if (bus.adc_cnv && !prev_cnv) begin
                if (last_rise >= 0)
                    chk("cnv_period", (cyc - last_rise) % (int'(bus.rate_div) + 1), 0);
                last_rise = cyc;
                rise_cyc  = cyc;
            end
            if (!bus.adc_cnv && prev_cnv) begin
                chk("cnv_high_time", cyc - rise_cyc, c_CNV_HIGH);
                fall_cyc = cyc;
            end
            if (bus.start_conversion) chk("conv_wait", cyc - fall_cyc, c_CONV_WAIT);
            if (bus.conversion_done) last_done_cyc = cyc;
            if (bus.start_reg_write) begin
                chk("wr_data", bus.reg_write_data, exp_wr_data);
                wr_starts++;
                wr_start_cyc = cyc;
            end
            if (prev_wdone || bus.reg_write_ack) chk("wr_ack_timing", bus.reg_write_ack, prev_wdone);
            prev_wdone = bus.reg_write_done;
        end
        prev_cnv = bus.adc_cnv;
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_adc_cnv"},   bus.adc_cnv, 0);
        chk({tag, "_start_cv"},  bus.start_conversion, 0);
        chk({tag, "_start_wr"},  bus.start_reg_write, 0);
        chk({tag, "_wr_data"},   bus.reg_write_data, 0);
        chk({tag, "_wr_ack"},    bus.reg_write_ack, 0);
        chk({tag, "_tvalid"},    bus.m_axis_tvalid, 0);
        chk({tag, "_tdata"},     bus.m_axis_tdata, 0);
        chk({tag, "_overrun"},   bus.overrun, 0);
        chk({tag, "_missed"},    bus.missed_tick, 0);
`ifdef ADC_ACQ_DROP_COUNT_EN
        chk({tag, "_drop_cnt"},  bus.drop_count, 0);
`endif
    endtask

    task automatic wait_samples(input int target, input int bound, input string nm);
        int k;
        for (k = 0; k < bound && smp_n < target; k++) @(negedge clk);
        chk(nm, smp_n >= target, 1);
    endtask

    // waits for reg_write_ack and drops the request in the ack cycle
    task automatic wait_ack(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (bus.reg_write_ack) begin
                got = 1'b1;
                bus.reg_write_req = 1'b0;
            end
        end
        chk(nm, got, 1);
    endtask

    task automatic host_write(input logic [23:0] d);
        step(1);
        exp_wr_data            = d;
        bus.reg_write_req_data = d;
        bus.reg_write_req      = 1'b1;
        wait_ack("wr_ack_seen");
    endtask

    task automatic pulse_clear();
        bus.clear_status = 1'b1;
        step(1);
        bus.clear_status = 1'b0;
        @(negedge clk);
    endtask

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        int s0, d0, w0, rd;
        bus.enable = 1'b0; bus.rate_div = 16'd0; bus.clear_status = 1'b0;
        bus.reg_write_req = 1'b0; bus.reg_write_req_data = 24'h0;

        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        step(1);
        rstn = 1'b1;

        // fixed rate 100 cycles: first tick on the first enabled cycle
        tready_mode  = 1;
        step(2);
        bus.rate_div = 16'd99;
        bus.enable   = 1'b1;
        @(negedge clk);
        chk("first_tick_cnv_low", bus.adc_cnv, 0);
        @(negedge clk);
        chk("first_tick_cnv_high", bus.adc_cnv, 1);
        step(600);
        bus.enable = 1'b0;
        step(100);
        chk("rate100_samples", smp_n >= 6, 1);
        chk("rate100_drained", exp_q.size(), 0);
        chk("rate100_missed", bus.missed_tick, 0);
        chk("rate100_overrun", bus.overrun, 0);

        // random rates longer than the sequence, random tready
        for (int it = 0; it < 4; it++) begin
            rd = $urandom_range(60, 150);
            bus.rate_div = 16'(rd);
            tready_mode  = 2;
            bus.enable   = 1'b1;
            step(4 * (rd + 1));
            bus.enable   = 1'b0;
            step(70);
        end
        tready_mode = 1;
        step(20);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_missed", bus.missed_tick, 0);
        chk("rand_overrun", bus.overrun, 0);

        // period shorter than the sequence: ticks are missed, sequences finish
        bus.rate_div = 16'd9;
        bus.enable   = 1'b1;
        step(300);
        bus.enable   = 1'b0;
        step(80);
        @(negedge clk);
        chk("short_missed_set", bus.missed_tick, 1);
        chk("short_overrun", bus.overrun, 0);
        chk("short_drained", exp_q.size(), 0);
        step(1);
        pulse_clear();
        chk("short_missed_cleared", bus.missed_tick, 0);

        // overflow: sink stalled for 20 samples
        step(1);
        tready_mode  = 0;
        s0           = smp_n;
        bus.rate_div = 16'd59;
        bus.enable   = 1'b1;
        wait_samples(s0 + 20, 2000, "ovf_samples_arrived");
        step(1);
        bus.enable = 1'b0;
        step(80);
        @(negedge clk);
        chk("ovf_overrun", bus.overrun, 1);
        chk("ovf_tvalid", bus.m_axis_tvalid, 1);
`ifdef ADC_ACQ_DROP_COUNT_EN
        chk("ovf_drop_count", bus.drop_count, 4);
`endif
        d0 = drained;
        step(1);
        tready_mode = 1;
        step(40);
        @(negedge clk);
        chk("ovf_drain_count", drained - d0, c_DEPTH);
        chk("ovf_drain_empty", bus.m_axis_tvalid, 0);
        step(1);
        pulse_clear();
        chk("ovf_overrun_cleared", bus.overrun, 0);
`ifdef ADC_ACQ_DROP_COUNT_EN
        chk("ovf_drop_count_cleared", bus.drop_count, 0);
`endif

        // register writes while sampling is disabled
        w0 = wr_starts;
        host_write(24'h12_3456);
        for (int k = 0; k < 2; k++) host_write(24'($urandom));
        step(5);
        chk("wr_start_count", wr_starts - w0, 3);

        // tick and write request in the same idle cycle: conversion first
        step(1);
        bus.rate_div           = 16'd999;
        exp_wr_data            = 24'hAB_CDEF;
        bus.reg_write_req_data = 24'hAB_CDEF;
        bus.reg_write_req      = 1'b1;
        bus.enable             = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("prio_cnv_first", bus.adc_cnv, 1);
        chk("prio_no_write", bus.start_reg_write, 0);
        wait_ack("prio_wr_ack_seen");
        chk("prio_write_after_conv", wr_start_cyc, last_done_cyc + 2);
        step(1);
        bus.enable = 1'b0;
        step(20);

        // reset asserted while waiting for conversion_done
        tready_mode  = 0;
        s0           = smp_n;
        bus.rate_div = 16'd99;
        bus.enable   = 1'b1;
        wait_samples(s0 + 2, 400, "rst_samples_arrived");
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                @(negedge clk);
                seen = bus.start_conversion;
            end
            chk("rst_read_reached", seen, 1);
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        bus.enable = 1'b0;
        #1;
        check_all_zero("reset_in_read");
        step(3);
        rstn = 1'b1;
        tready_mode = 1;
        @(negedge clk);
        check_all_zero("after_reset");

        // normal operation resumes
        step(1);
        bus.enable = 1'b1;
        step(350);
        bus.enable = 1'b0;
        step(80);
        chk("resume_drained", exp_q.size(), 0);
        chk("resume_missed", bus.missed_tick, 0);
        chk("resume_overrun", bus.overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
